// File: rtl/vsu_pkg.sv
// rtl/vsu_pkg.sv - shared opcodes, FSM states and error-return constant for vec_mem_stream_unit
package vsu_pkg;

    localparam logic [4:0]  OP_VLOAD  = 5'b00000;
    localparam logic [4:0]  OP_VSTORE = 5'b00001;
    localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        ST_VALID = 2'd2
    } vsu_state_e;

endpackage

// File: rtl/vsu_sync_fifo.sv
// rtl/vsu_sync_fifo.sv - synchronous FIFO with registered head and full/empty flags
module vsu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vec_mem_stream_unit.sv
// rtl/vec_mem_stream_unit.sv - VRF load/store stream unit with exec FIFO; VSU_BOUNDS_CHECK_EN adds err_o
module vec_mem_stream_unit
    import vsu_pkg::*;
#(
    parameter int NUM_ELEMS       = 32,
    parameter int IDX_W           = $clog2(NUM_ELEMS),
    parameter int DATA_W          = 32,
    parameter int EXEC_FIFO_DEPTH = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [31:0]       instruction_recv_msg,
    input  logic              instruction_recv_val,
    output logic              instruction_recv_rdy,
    input  logic [63:0]       load_recv_msg,
    input  logic              load_recv_val,
    output logic              load_recv_rdy,
    output logic [DATA_W-1:0] store_send_msg,
    output logic              store_send_val,
    input  logic              store_send_rdy,
    output logic              vrf_wr_en,
    output logic [IDX_W-1:0]  vrf_wr_addr,
    output logic [DATA_W-1:0] vrf_wr_data,
    output logic              vrf_rd_en,
    output logic [IDX_W-1:0]  vrf_rd_addr,
    input  logic [DATA_W-1:0] vrf_rd_data,
    output logic [31:0]       exec_send_msg,
    output logic              exec_send_val,
    input  logic              exec_send_rdy,
    output logic              busy_o
`ifdef VSU_BOUNDS_CHECK_EN
    ,
    output logic              err_o
`endif
);

    vsu_state_e        state;
    logic [DATA_W-1:0] store_data;
    logic              rd_err;
    logic [4:0]        opcode;
    logic              is_vload;
    logic              is_vstore;
    logic              is_exec;
    logic [IDX_W-1:0]  idx;
    logic              both_val;
    logic              in_idle;
    logic              oob;
    logic              store_req;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic              unused_idx_hi;

    assign opcode    = instruction_recv_msg[31:27];
    assign is_vload  = (opcode == OP_VLOAD);
    assign is_vstore = (opcode == OP_VSTORE);
    assign is_exec   = !is_vload && !is_vstore;
    assign idx       = load_recv_msg[32 +: IDX_W];
    assign both_val  = instruction_recv_val && load_recv_val;
    // Handshake outputs are combinational, so hold them low while reset is asserted
    assign in_idle   = (state == IDLE) && !wb_rst_i;
    assign unused_idx_hi = &{1'b0, load_recv_msg[63:32+IDX_W]};

`ifdef VSU_BOUNDS_CHECK_EN
    assign oob = (load_recv_msg[63:32] >= 32'(NUM_ELEMS));
`else
    assign oob = 1'b0;
`endif

    assign store_req = in_idle && is_vstore && both_val;
    assign fifo_push = in_idle && is_exec && instruction_recv_val && !fifo_full;

    always_comb begin
        instruction_recv_rdy = 1'b0;
        load_recv_rdy        = 1'b0;
        vrf_wr_en            = 1'b0;
        vrf_wr_addr          = '0;
        vrf_wr_data          = '0;
        vrf_rd_en            = 1'b0;
        vrf_rd_addr          = '0;
        if (in_idle) begin
            if (is_vload) begin
                instruction_recv_rdy = both_val;
                load_recv_rdy        = both_val;
                if (both_val && !oob) begin
                    vrf_wr_en   = 1'b1;
                    vrf_wr_addr = idx;
                    vrf_wr_data = load_recv_msg[DATA_W-1:0];
                end
            end else if (is_vstore) begin
                // VSTORE completes only through the store stream handshake
                if (both_val && !oob) begin
                    vrf_rd_en   = 1'b1;
                    vrf_rd_addr = idx;
                end
            end else begin
                instruction_recv_rdy = !fifo_full;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            store_data <= '0;
            rd_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (store_req) begin
                        state  <= RD_WAIT;
                        rd_err <= oob;
                    end
                end
                RD_WAIT: begin
                    store_data <= rd_err ? ERR_DATA[DATA_W-1:0] : vrf_rd_data;
                    state      <= ST_VALID;
                end
                ST_VALID: begin
                    // Either the store completes or the bus cycle was abandoned upstream
                    if (store_send_rdy || !instruction_recv_val) begin
                        state      <= IDLE;
                        store_data <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VSU_BOUNDS_CHECK_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            err_o <= 1'b0;
        end else if (in_idle && both_val && (is_vload || is_vstore) && oob) begin
            err_o <= 1'b1;
        end
    end
`endif

    assign store_send_val = (state == ST_VALID);
    assign store_send_msg = store_send_val ? store_data : '0;
    assign busy_o         = (state != IDLE);
    assign exec_send_val  = !fifo_empty;

    vsu_sync_fifo #(
        .WIDTH (32),
        .DEPTH (EXEC_FIFO_DEPTH)
    ) u_exec_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (fifo_push),
        .push_data (instruction_recv_msg),
        .pop       (exec_send_rdy),
        .head      (exec_send_msg),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_vec_mem_stream_unit.sv
// tb/tb_vec_mem_stream_unit.sv - directed table and sequence bench for vec_mem_stream_unit
module tb_vec_mem_stream_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        ival = 1'b0;
    logic        irdy;
    logic [63:0] load = '0;
    logic        lval = 1'b0;
    logic        lrdy;
    logic [31:0] st_msg;
    logic        st_val;
    logic        st_rdy = 1'b0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data = '0;
    logic [31:0] ex_msg;
    logic        ex_val;
    logic        ex_rdy = 1'b0;
    logic        busy;
`ifdef VSU_BOUNDS_CHECK_EN
    logic        err;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] vrf [32];

    always #5 clk = ~clk;

    vec_mem_stream_unit dut (
        .wb_clk_i             (clk),
        .wb_rst_i             (rst),
        .instruction_recv_msg (instr),
        .instruction_recv_val (ival),
        .instruction_recv_rdy (irdy),
        .load_recv_msg        (load),
        .load_recv_val        (lval),
        .load_recv_rdy        (lrdy),
        .store_send_msg       (st_msg),
        .store_send_val       (st_val),
        .store_send_rdy       (st_rdy),
        .vrf_wr_en            (wr_en),
        .vrf_wr_addr          (wr_addr),
        .vrf_wr_data          (wr_data),
        .vrf_rd_en            (rd_en),
        .vrf_rd_addr          (rd_addr),
        .vrf_rd_data          (rd_data),
        .exec_send_msg        (ex_msg),
        .exec_send_val        (ex_val),
        .exec_send_rdy        (ex_rdy),
        .busy_o               (busy)
`ifdef VSU_BOUNDS_CHECK_EN
        ,
        .err_o                (err)
`endif
    );

    // VRF model: write on strobe, read data one cycle after the read strobe
    always @(posedge clk) begin
        if (wr_en) vrf[wr_addr] <= wr_data;
        if (rd_en) rd_data <= vrf[rd_addr];
    end

    typedef struct {
        logic [31:0] instr;
        logic        ival;
        logic [63:0] load;
        logic        lval;
        logic        e_irdy;
        logic        e_lrdy;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_ren;
    } vec_t;

    localparam logic [31:0] I_VLOAD  = 32'h0000_0000;
    localparam logic [31:0] I_VSTORE = 32'h0800_0000;
    localparam logic [31:0] I_EXEC2  = 32'h1000_0000;
    localparam logic [31:0] I_EXEC3  = 32'h1800_0000;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    vec_t vec [7];

    initial begin
        for (int i = 0; i < 32; i++) vrf[i] = '0;

        vec[0] = '{I_VLOAD, 1'b1, {32'd5, 32'h1234_5678}, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0};
        vec[1] = '{I_VLOAD, 1'b0, {32'd6, 32'h0000_1111}, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0};
        vec[2] = '{I_VLOAD, 1'b1, {32'd6, 32'h0000_2222}, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0};
        vec[3] = '{I_VLOAD, 1'b1, {32'd7, 32'hCAFE_0001}, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 32'hCAFE_0001, 1'b0};
        vec[4] = '{I_EXEC3 | 32'h42, 1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0};
`ifdef VSU_BOUNDS_CHECK_EN
        vec[5] = '{I_VLOAD, 1'b1, {32'd40, 32'hA5A5_A5A5}, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
`else
        vec[5] = '{I_VLOAD, 1'b1, {32'd40, 32'hA5A5_A5A5}, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 32'hA5A5_A5A5, 1'b0};
`endif
        vec[6] = '{I_VSTORE, 1'b1, {32'd7, 32'h0}, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0};

        // Reset state
        #2;
        chk("reset_in_rst", {irdy, lrdy, st_val, st_msg, wr_en, rd_en, ex_val, busy}, 64'h0);
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("reset_outs", {irdy, lrdy, st_val, st_msg, wr_en, rd_en, ex_val, busy}, 64'h0);
        chk("reset_exec_msg", {32'h0, ex_msg}, 64'h0);

        // Single-cycle IDLE vectors
        ex_rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            instr = vec[i].instr; ival = vec[i].ival; load = vec[i].load; lval = vec[i].lval;
            #1;
            chk($sformatf("vec%0d_rdy", i), {62'h0, irdy, lrdy}, {62'h0, vec[i].e_irdy, vec[i].e_lrdy});
            chk($sformatf("vec%0d_wr", i), {26'h0, wr_en, wr_addr, wr_data}, {26'h0, vec[i].e_wen, vec[i].e_waddr, vec[i].e_wdata});
            chk($sformatf("vec%0d_rd", i), {63'h0, rd_en}, {63'h0, vec[i].e_ren});
            cyc();
            ival = 1'b0; lval = 1'b0;
        end
        cyc();
        chk("busy_after_table", {63'h0, busy}, 64'h0);
        chk("fifo_drained", {63'h0, ex_val}, 64'h0);
`ifdef VSU_BOUNDS_CHECK_EN
        chk("err_set_oob_load", {63'h0, err}, 64'h1);
`endif

        // VSTORE of element 7 with 2-cycle latency, handshake one cycle late
        instr = I_VSTORE; load = {32'd7, 32'h0}; ival = 1'b1; lval = 1'b1;
        #1;
        chk("st_T_rd", {57'h0, rd_en, rd_addr, irdy}, {57'h0, 1'b1, 5'd7, 1'b0});
        chk("st_T_lrdy", {63'h0, lrdy}, 64'h0);
        cyc();
        chk("st_T1", {62'h0, st_val, busy}, {62'h0, 1'b0, 1'b1});
        cyc();
        chk("st_T2", {31'h0, st_val, st_msg}, {31'h0, 1'b1, 32'hCAFE_0001});
        cyc();
        chk("st_T3_hold", {31'h0, st_val, st_msg}, {31'h0, 1'b1, 32'hCAFE_0001});
        st_rdy = 1'b1;
        cyc();
        ival = 1'b0; lval = 1'b0; st_rdy = 1'b0;
        #1;
        chk("st_done", {31'h0, st_val, st_msg, busy}, 64'h0);
        cyc();

        // EXEC FIFO fill with compute stalled, then ordered drain
        ex_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            instr = I_EXEC2 | 32'(k + 1); ival = 1'b1;
            #1;
            chk($sformatf("exec_push%0d_rdy", k), {63'h0, irdy}, {63'h0, (k < 4)});
            chk($sformatf("exec_push%0d_lrdy", k), {63'h0, lrdy}, 64'h0);
            cyc();
        end
        ival = 1'b0;
        ex_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("exec_pop%0d", k), {31'h0, ex_val, ex_msg}, {31'h0, 1'b1, I_EXEC2 | 32'(k + 1)});
            cyc();
        end
        #1;
        chk("exec_empty", {63'h0, ex_val}, 64'h0);
        cyc();

        // Abort while ST_VALID, then a VLOAD is accepted
        instr = I_VSTORE; load = {32'd5, 32'h0}; ival = 1'b1; lval = 1'b1;
        cyc(); cyc();
        chk("abort_stvalid", {31'h0, st_val, st_msg}, {31'h0, 1'b1, 32'h1234_5678});
        ival = 1'b0; lval = 1'b0;
        cyc();
        chk("abort_idle", {31'h0, st_val, busy, st_msg}, 64'h0);
        instr = I_VLOAD; load = {32'd3, 32'h0000_0055}; ival = 1'b1; lval = 1'b1;
        #1;
        chk("abort_next_vload", {25'h0, irdy, lrdy, wr_en, wr_addr, wr_data}, {25'h0, 3'b111, 5'd3, 32'h55});
        cyc();
        ival = 1'b0; lval = 1'b0;
`ifdef VSU_BOUNDS_CHECK_EN
        chk("err_sticky", {63'h0, err}, 64'h1);
`endif
        cyc();

        // Asynchronous reset during RD_WAIT
        instr = I_VSTORE; load = {32'd7, 32'h0}; ival = 1'b1; lval = 1'b1;
        cyc();
        chk("rst_rdwait_busy", {63'h0, busy}, 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outs", {irdy, lrdy, st_val, st_msg, wr_en, rd_en, busy}, 64'h0);
`ifdef VSU_BOUNDS_CHECK_EN
        chk("rst_err_clear", {63'h0, err}, 64'h0);
`endif
        ival = 1'b0; lval = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst_after1", {62'h0, st_val, busy}, 64'h0);
        cyc();
        chk("rst_after2", {62'h0, st_val, busy}, 64'h0);

`ifdef VSU_BOUNDS_CHECK_EN
        // Out-of-range VSTORE returns the error word without a VRF read
        instr = I_VSTORE; load = {32'd40, 32'h0}; ival = 1'b1; lval = 1'b1;
        #1;
        chk("oob_st_rd", {63'h0, rd_en}, 64'h0);
        cyc(); cyc();
        chk("oob_st_data", {31'h0, st_val, st_msg}, {31'h0, 1'b1, 32'hDEAD_BEEF});
        chk("oob_st_err", {63'h0, err}, 64'h1);
        st_rdy = 1'b1;
        cyc();
        ival = 1'b0; lval = 1'b0; st_rdy = 1'b0;
        cyc();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
